stream_upsizer: RTL and testbench
=================================

STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 SHALL have parameter InWidth, default 8, meaning bit width of one input beat (>=1).
REQ-002 SHALL have parameter Ratio, default 4, meaning input beats per output word (>=2).
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr_i  input  1  synchronous clear.
REQ-006 SHALL have port valid_i  input  1  input beat valid.
REQ-007 SHALL have port ready_o  output  1  input beat ready.
REQ-008 SHALL have port data_i  input  InWidth  input beat payload.
REQ-009 SHALL have port last_i  input  1  beat closes the current word early (part of payload, sampled with data_i).
REQ-010 SHALL have port valid_o  output  1  output word valid.
REQ-011 SHALL have port ready_i  input  1  output word ready.
REQ-012 SHALL have port data_o  output  InWidth*Ratio  packed output word.
REQ-013 SHALL have port strb_o  output  Ratio  per-lane filled mask of data_o.

Function
REQ-014 Input handshake SHALL occur when valid_i & ready_o; output handshake when valid_o & ready_i.
REQ-015 ready_o SHALL equal ready_i | ~valid_o, independent of valid_i, data_i and last_i.
REQ-016 An internal lane counter idx (width $clog2(Ratio)) SHALL select the lane for each accepted beat; beat at idx=k lands in bits [k*InWidth +: InWidth].
REQ-017 Accepted beat SHALL be "closing" when idx==Ratio-1 or last_i==1; otherwise it is written into the assembly buffer and idx increments by 1.
REQ-018 On a closing beat the assembled lanes plus the current beat SHALL load the output register, idx returns to 0, and the assembly buffer and its lane mask clear, all in the same edge.
REQ-019 Output latency SHALL be one cycle: valid_o rises in the cycle after the closing handshake.
REQ-020 Unfilled lanes of data_o SHALL read zero; strb_o bit k SHALL be 1 iff lane k was filled for that word (contiguous from bit 0).
REQ-021 valid_o, data_o and strb_o SHALL hold stable while valid_o & ~ready_i.
REQ-022 Simultaneous output handshake and closing input beat SHALL replace the word in the same edge, giving one word per Ratio cycles sustained.
REQ-023 Non-closing beats SHALL also stall when ready_o==0 (no bypass of the output stall).
REQ-024 last_i on the first beat (idx==0) SHALL produce a word with strb_o==1.
REQ-025 clr_i SHALL, at the next edge, zero idx, assembly buffer, lane mask, valid_o, data_o and strb_o, with priority over any handshake in that cycle; the beat presented is dropped.

Reset
REQ-026 On rst_ni low, asynchronously: valid_o=0, data_o=0, strb_o=0, idx=0, assembly buffer and lane mask=0; ready_o therefore reads 1.
REQ-027 Reset mid-word SHALL discard the partial word; the first beat after release lands in lane 0.

Structure
REQ-028 No shared package entries SHALL be added; the word-plus-mask struct is derived locally from parameters.
REQ-029 The output register SHALL be an instance of stream_register with T = {data, strb} struct, valid_i driven by the closing-beat handshake, sharing clk_i/rst_ni/clr_i.
REQ-030 Assembly buffer and idx SHALL use the codebase's load-enable async-reset-with-clear register macros.

Verification (InWidth=8, Ratio=4)
REQ-031 Beats 0x11,0x22,0x33,0x44 back-to-back, ready_i=1 -> one word data_o=0x44332211, strb_o=0xF, valid_o one cycle after 4th beat.
REQ-032 Beats 0xAA,0xBB with last_i on 0xBB -> data_o=0x0000BBAA, strb_o=0x3; next beat 0xCC lands in lane 0.
REQ-033 ready_i=0 with word held, 3 more beats offered -> ready_o=0, data_o unchanged; ready_i=1 -> word drains, beats resume into lanes 0..2.
REQ-034 Continuous stream of 12 beats, ready_i=1 -> exactly 3 words, no beat lost or duplicated, ready_o stays 1.
REQ-035 clr_i pulsed after 2 beats and again with valid_o=1 -> valid_o=0, next word starts at lane 0 with strb_o counted from zero.
REQ-036 rst_ni asserted asynchronously mid-word -> outputs zero immediately; post-release single last_i beat 0x5A gives data_o=0x0000005A, strb_o=0x1.

Source files
------------

// File: rtl/stream_upsizer_pkg.sv
// Shared helpers for the stream upsizer: index-width sizing for the lane counter.
package stream_upsizer_pkg;

  // Lane counter width; a ratio of 1 would otherwise yield a zero-width counter.
  function automatic int unsigned idx_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_upsizer_register.sv
// One-deep valid/ready pipeline register carrying an arbitrary packed payload type.
module stream_register #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  // Handshake: a transfer happens on an edge where valid & ready are both high;
  // once valid_o is raised, valid_o and data_o hold until ready_i accepts them.
  logic r_valid;
  T     r_data;

  assign ready_o = ready_i | ~r_valid;
  assign valid_o = r_valid;
  assign data_o  = r_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (clr_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (valid_i && ready_o) begin
      r_valid <= 1'b1;
      r_data  <= data_i;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_upsizer.sv
// Packs Ratio narrow beats into one wide word with a per-lane fill mask; last_i closes early.
module stream_upsizer
  import stream_upsizer_pkg::*;
#(
  parameter int unsigned InWidth = 8,
  parameter int unsigned Ratio   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [InWidth-1:0]         data_i,
  input  logic                       last_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [InWidth*Ratio-1:0]   data_o,
  output logic [Ratio-1:0]           strb_o
);

  localparam int unsigned IdxW = idx_width(Ratio);
  localparam int unsigned DW   = InWidth * Ratio;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [Ratio-1:0] strb;
  } word_t;

  logic [DW-1:0]    r_buf;
  logic [Ratio-1:0] r_mask;
  logic [IdxW-1:0]  r_idx;

  logic             w_ready;
  logic             w_in_hs;
  logic             w_closing;
  logic [DW-1:0]    w_lane_data;
  logic [Ratio-1:0] w_lane_mask;
  word_t            w_word;
  word_t            w_out;

  assign w_in_hs   = valid_i & w_ready;
  assign w_closing = w_in_hs & ((r_idx == LastIdx) | last_i);
  assign ready_o   = w_ready;

  // Steer the current beat into the lane chosen by the counter.
  always_comb begin
    w_lane_data = '0;
    w_lane_mask = '0;
    for (int k = 0; k < Ratio; k++) begin
      if (r_idx == IdxW'(k)) begin
        w_lane_data[k*InWidth +: InWidth] = data_i;
        w_lane_mask[k]                    = 1'b1;
      end
    end
  end

  assign w_word.data = r_buf | w_lane_data;
  assign w_word.strb = r_mask | w_lane_mask;

  // Assembly buffer: accumulates non-closing beats, empties when a word is handed off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf  <= '0;
      r_mask <= '0;
      r_idx  <= '0;
    end else if (clr_i) begin
      r_buf  <= '0;
      r_mask <= '0;
      r_idx  <= '0;
    end else if (w_in_hs) begin
      if (w_closing) begin
        r_buf  <= '0;
        r_mask <= '0;
        r_idx  <= '0;
      end else begin
        r_buf  <= w_word.data;
        r_mask <= w_word.strb;
        r_idx  <= r_idx + IdxW'(1);
      end
    end
  end

  stream_register #(
    .T (word_t)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .valid_i (w_closing),
    .ready_o (w_ready),
    .data_i  (w_word),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (w_out)
  );

  assign data_o = w_out.data;
  assign strb_o = w_out.strb;

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer (InWidth=8, Ratio=4) with a queue-based output scoreboard.
module tb_stream_upsizer;

  localparam int InWidth = 8;
  localparam int Ratio   = 4;
  localparam int DW      = InWidth * Ratio;
  localparam int W       = DW + Ratio;

  logic               clk_i;
  logic               rst_ni;
  logic               clr_i;
  logic               valid_i;
  logic               ready_o;
  logic [InWidth-1:0] data_i;
  logic               last_i;
  logic               valid_o;
  logic               ready_i;
  logic [DW-1:0]      data_o;
  logic [Ratio-1:0]   strb_o;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_words = 0;

  stream_upsizer #(
    .InWidth (InWidth),
    .Ratio   (Ratio)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .strb_o  (strb_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [Ratio-1:0] s);
    exp_q.push_back({d, s});
  endtask

  // driver: present one beat and hold it until accepted
  task automatic send(input logic [InWidth-1:0] d, input logic l);
    int guard;
    guard   = 0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    while (!ready_o && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got ready_o=0 expected ready_o=1 within 50 cycles");
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
  endtask

  // scoreboard monitor: a handshake will occur at the next rising edge
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i) begin
      n_words++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'({data_o, strb_o}), 64'hDEAD_BEEF_0);
      end else begin
        check("word", 64'({data_o, strb_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int words_before;
    rst_ni  = 1'b0;
    clr_i   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    last_i  = 1'b0;
    ready_i = 1'b1;
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    check("rst_data_o",  64'(data_o),  64'd0);
    check("rst_strb_o",  64'(strb_o),  64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // full word, back-to-back, one-cycle latency
    push_exp(32'h44332211, 4'hF);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("no_early_valid", 64'(valid_o), 64'd0);
    send(8'h44, 1'b0);
    check("latency_valid", 64'(valid_o), 64'd1);
    check("latency_strb",  64'(strb_o),  64'hF);

    // early close, then next beat restarts at lane 0
    push_exp(32'h0000BBAA, 4'h3);
    push_exp(32'hFFEEDDCC, 4'hF);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check("early_strb", 64'(strb_o), 64'h3);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    send(8'hEE, 1'b0);
    send(8'hFF, 1'b0);
    @(posedge clk_i); #1;

    // output stall blocks further beats
    ready_i = 1'b0;
    push_exp(32'h04030201, 4'hF);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    valid_i = 1'b1;
    data_i  = 8'h10;
    last_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("stall_ready_o", 64'(ready_o), 64'd0);
      check("stall_data_o",  64'(data_o),  64'h04030201);
      check("stall_valid_o", 64'(valid_o), 64'd1);
    end
    push_exp(32'h00302010, 4'h7);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    @(posedge clk_i); #1;

    // sustained stream: 12 beats -> 3 words
    push_exp(32'hA3A2A1A0, 4'hF);
    push_exp(32'hA7A6A5A4, 4'hF);
    push_exp(32'hABAAA9A8, 4'hF);
    words_before = n_words;
    for (int i = 0; i < 12; i++) begin
      check("stream_ready_o", 64'(ready_o), 64'd1);
      send(8'(8'hA0 + i), 1'b0);
    end
    @(posedge clk_i); #1;
    check("stream_word_count", 64'(n_words - words_before), 64'd3);

    // clear after a partial word
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    pulse_clr();
    check("clr_partial_valid", 64'(valid_o), 64'd0);
    push_exp(32'h00006655, 4'h3);
    send(8'h55, 1'b0);
    send(8'h66, 1'b1);
    @(posedge clk_i); #1;

    // clear while a word is held
    ready_i = 1'b0;
    send(8'h77, 1'b1);
    check("held_before_clr", 64'(valid_o), 64'd1);
    pulse_clr();
    check("clr_held_valid", 64'(valid_o), 64'd0);
    check("clr_held_data",  64'(data_o),  64'd0);
    check("clr_held_strb",  64'(strb_o),  64'd0);
    ready_i = 1'b1;
    push_exp(32'h00000088, 4'h1);
    send(8'h88, 1'b1);
    @(posedge clk_i); #1;

    // async reset with a held word: outputs drop before any edge
    ready_i = 1'b0;
    send(8'h99, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid_o", 64'(valid_o), 64'd0);
    check("arst_data_o",  64'(data_o),  64'd0);
    check("arst_strb_o",  64'(strb_o),  64'd0);
    check("arst_ready_o", 64'(ready_o), 64'd1);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    ready_i = 1'b1;

    // async reset mid-word discards the partial word
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    #2 rst_ni = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    push_exp(32'h0000005A, 4'h1);
    send(8'h5A, 1'b1);
    check("post_rst_strb", 64'(strb_o), 64'h1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
